sine_ram_sched: RTL

Single-port RAM scheduler that shares the 256x8 read-first sine table RAM between a write (table patch) requester and a DDS-style playback reader. Playback steps a phase accumulator, reads `ram[phase[PW-1 -: AW]]` and emits one registered sample per granted read. Write requests use a valid/ready handshake. On contention, access alternates between reader and writer. The block sits directly in front of the sine RAM and owns all of its address, write-enable and data-in pins.

---
 rtl/sine_ram_sched_if.sv | 25 ++
 rtl/sine_ram_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sine_ram_sched_if.sv
// Write-request channel into the sine RAM scheduler: valid/ready handshake
// carrying a table-patch address and data word.
interface sine_ram_sched_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/sine_ram_sched.sv
// Single-port sine RAM scheduler: arbitrates between table-patch writes and a
// DDS phase-accumulator playback reader, alternating on contention.
module sine_ram_sched #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int PW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PW-1:0]       phase_inc,
  sine_ram_sched_if.slave     wr,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_we,
  output logic [DW-1:0]       ram_din,
  input  logic [DW-1:0]       ram_qout,
  output logic [DW-1:0]       sample,
  output logic                sample_valid,
  output logic [7:0]          skip_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } gnt_t;

  state_t        state_reg, state_next;
  logic          drain_cnt_reg, drain_cnt_next;
  gnt_t          last_gnt_reg, last_gnt_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [7:0]    skip_cnt_reg, skip_cnt_next;
  logic          rd_gnt_d1_reg, rd_gnt_d2_reg;
  logic [DW-1:0] sample_reg, sample_next;

  logic rd_req, wr_req;
  logic rd_gnt, wr_gnt;

  // ---------------------------------------------------------------------------
  // Playback state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // DRAIN lasts two cycles so reads issued in the last PLAY cycles surface
  // as samples before IDLE; re-enabling during DRAIN resumes PLAY at once.
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (en) state_next = PLAY;
      end
      PLAY: begin
        if (!en) begin
          state_next     = DRAIN;
          drain_cnt_next = 1'b0;
        end
      end
      DRAIN: begin
        if (en) begin
          state_next = PLAY;
        end else if (drain_cnt_reg) begin
          state_next = IDLE;
        end else begin
          drain_cnt_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arbitration: fixed grant for a lone requester, otherwise whoever lost last
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_req = (state_reg == PLAY) && !rst;
    wr_req = wr.wr_valid && !rst;
    rd_gnt = rd_req && (!wr_req || (last_gnt_reg == GNT_WR));
    wr_gnt = wr_req && !rd_gnt;
  end

  always_comb begin
    last_gnt_next = last_gnt_reg;
    if (rd_gnt)      last_gnt_next = GNT_RD;
    else if (wr_gnt) last_gnt_next = GNT_WR;
  end

  // ---------------------------------------------------------------------------
  // RAM port drive
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    if (wr_gnt) begin
      ram_we   = 1'b1;
      ram_addr = wr.wr_addr;
    end else if (rd_gnt) begin
      ram_addr = phase_reg[PW-1 -: AW];
    end
  end

  assign ram_din     = wr.wr_data;
  assign wr.wr_ready = wr_gnt;

  // ---------------------------------------------------------------------------
  // Phase accumulator and skip counter
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_next = phase_reg;
    if (rd_gnt) phase_next = phase_reg + phase_inc;
  end

  // Only a stalled PLAY cycle counts as a skip; idle-time writes are free.
  always_comb begin
    skip_cnt_next = skip_cnt_reg;
    if (rd_req && wr_gnt && (skip_cnt_reg != 8'hFF))
      skip_cnt_next = skip_cnt_reg + 8'd1;
  end

  always_comb begin
    sample_next = sample_reg;
    if (rd_gnt_d1_reg) sample_next = ram_qout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_reg  <= GNT_WR;
      phase_reg     <= '0;
      skip_cnt_reg  <= 8'd0;
      rd_gnt_d1_reg <= 1'b0;
      rd_gnt_d2_reg <= 1'b0;
      sample_reg    <= '0;
    end else begin
      last_gnt_reg  <= last_gnt_next;
      phase_reg     <= phase_next;
      skip_cnt_reg  <= skip_cnt_next;
      rd_gnt_d1_reg <= rd_gnt;
      rd_gnt_d2_reg <= rd_gnt_d1_reg;
      sample_reg    <= sample_next;
    end
  end

  assign sample       = sample_reg;
  assign sample_valid = rd_gnt_d2_reg;
  assign skip_cnt     = skip_cnt_reg;

endmodule
